// File: rtl/noc_vc_fifo.sv
// Multi-virtual-channel first-word-fall-through flit FIFO.
// Each VC has private storage and pointers, and a single write port and a single read port are shared by all VCs.
module noc_vc_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 8,
   parameter int NUM_VC = 2,
   parameter int AF_LVL = DEPTH - 2,
   localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [VC_W-1:0]         wr_vc,
   input  logic [DATA_W-1:0]       din,
   input  logic                    rd_en,
   input  logic [VC_W-1:0]         rd_vc,
   output logic [DATA_W-1:0]       dout,
   output logic [NUM_VC-1:0]       empty,
   output logic [NUM_VC-1:0]       full,
   output logic [NUM_VC-1:0]       almost_full,
   output logic [NUM_VC*CNT_W-1:0] count,
   output logic                    polarity,
   output logic                    ovf_err,
   output logic                    udf_err
);

   localparam int AW = CNT_W - 1;
   localparam logic [VC_W:0]    NVC  = (VC_W + 1)'(NUM_VC);
   localparam logic [CNT_W-1:0] AF_C = CNT_W'(AF_LVL);

   logic [DATA_W-1:0] mem [NUM_VC][DEPTH];
   logic [CNT_W-1:0]  wptr [NUM_VC];
   logic [CNT_W-1:0]  rptr [NUM_VC];
   logic [CNT_W-1:0]  occ [NUM_VC];

   logic            wr_in_rng;
   logic            rd_in_rng;
   logic [VC_W-1:0] wr_idx;
   logic [VC_W-1:0] rd_idx;
   logic            rd_ok;
   logic            wr_ok;

   always_comb begin
      empty       = '0;
      full        = '0;
      almost_full = '0;
      count       = '0;
      for (int k = 0; k < NUM_VC; k++) begin
         occ[k]         = wptr[k] - rptr[k];
         empty[k]       = (wptr[k] == rptr[k]);
         full[k]        = (wptr[k][AW] != rptr[k][AW]) &&
                          (wptr[k][AW-1:0] == rptr[k][AW-1:0]);
         almost_full[k] = (occ[k] >= AF_C);
         count[k*CNT_W +: CNT_W] = occ[k];
      end
   end

   // Out-of-range VC numbers are refused; the index is parked on VC0 so no array is over-indexed.
   always_comb begin
      wr_in_rng = ({1'b0, wr_vc} < NVC);
      rd_in_rng = ({1'b0, rd_vc} < NVC);
      wr_idx    = wr_in_rng ? wr_vc : '0;
      rd_idx    = rd_in_rng ? rd_vc : '0;
      rd_ok     = rd_en && rd_in_rng && !empty[rd_idx];
      wr_ok     = wr_en && wr_in_rng &&
                  (!full[wr_idx] || (rd_ok && (rd_idx == wr_idx)));
   end

   assign dout = mem[rd_idx][rptr[rd_idx][AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_VC; k++) begin
            wptr[k] <= '0;
            rptr[k] <= '0;
         end
         polarity <= 1'b0;
         ovf_err  <= 1'b0;
         udf_err  <= 1'b0;
      end else begin
         polarity <= ~polarity;
         if (wr_en && !wr_ok) ovf_err <= 1'b1;
         if (rd_en && !rd_ok) udf_err <= 1'b1;
         for (int k = 0; k < NUM_VC; k++) begin
            if (wr_ok && (wr_idx == VC_W'(k))) wptr[k] <= wptr[k] + CNT_W'(1);
            if (rd_ok && (rd_idx == VC_W'(k))) rptr[k] <= rptr[k] + CNT_W'(1);
         end
      end
   end

   // Storage is deliberately not reset; clearing the pointers discards its contents.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_idx][wptr[wr_idx][AW-1:0]] <= din;
   end

endmodule

// File: tb/tb_noc_vc_fifo.sv
// Testbench for noc_vc_fifo: directed vector table, streaming, random traffic against a queue model, async reset.
module tb_noc_vc_fifo;
   localparam int DATA_W = 64;
   localparam int DEPTH  = 8;
   localparam int NUM_VC = 3;
   localparam int AF_LVL = 6;
   localparam int VC_W   = 2;
   localparam int CNT_W  = 4;
   localparam logic [63:0] A  = 64'hAAAA_0000_0000_00A0;
   localparam logic [63:0] B0 = 64'hBBBB_0000_0000_00B0;
   localparam logic [63:0] C0 = 64'hCCCC_0000_0000_00C0;
   localparam logic [63:0] S  = 64'h5555_0000_0000_0000;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    wr_en;
   logic [VC_W-1:0]         wr_vc;
   logic [DATA_W-1:0]       din;
   logic                    rd_en;
   logic [VC_W-1:0]         rd_vc;
   logic [DATA_W-1:0]       dout;
   logic [NUM_VC-1:0]       empty;
   logic [NUM_VC-1:0]       full;
   logic [NUM_VC-1:0]       almost_full;
   logic [NUM_VC*CNT_W-1:0] count;
   logic                    polarity;
   logic                    ovf_err;
   logic                    udf_err;

   noc_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_VC(NUM_VC), .AF_LVL(AF_LVL)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_vc(wr_vc), .din(din),
      .rd_en(rd_en), .rd_vc(rd_vc), .dout(dout), .empty(empty), .full(full),
      .almost_full(almost_full), .count(count), .polarity(polarity),
      .ovf_err(ovf_err), .udf_err(udf_err));

   always #5 clk = ~clk;

   logic [63:0] q [NUM_VC][$];
   bit exp_ovf, exp_udf, exp_pol;
   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          we;
      logic [1:0]  wvc;
      logic [63:0] d;
      bit          re;
      logic [1:0]  rvc;
      int          c0;
      int          c1;
      bit          ovf;
      bit          udf;
      bit          dchk;
      logic [63:0] dexp;
   } vec_t;
   vec_t tbl [22];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < NUM_VC; k++) q[k].delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
      exp_pol = 1'b0;
   endtask

   // Reference behaviour of one clock edge, from the queue sizes alone.
   task automatic model_edge();
      int rv, wv;
      bit rok, wok;
      rv  = int'(rd_vc);
      wv  = int'(wr_vc);
      rok = 1'b0;
      wok = 1'b0;
      if (rd_en && rv < NUM_VC) rok = (q[rv].size() > 0);
      if (wr_en && wv < NUM_VC) wok = (q[wv].size() < DEPTH) || (rok && rv == wv);
      if (rd_en && !rok) exp_udf = 1'b1;
      if (wr_en && !wok) exp_ovf = 1'b1;
      if (rok) void'(q[rv].pop_front());
      if (wok) q[wv].push_back(din);
      exp_pol = ~exp_pol;
   endtask

   task automatic check_all();
      logic [NUM_VC-1:0] e_empty, e_full, e_af;
      logic [NUM_VC*CNT_W-1:0] e_cnt;
      int rv;
      e_empty = '0; e_full = '0; e_af = '0; e_cnt = '0;
      for (int k = 0; k < NUM_VC; k++) begin
         e_empty[k] = (q[k].size() == 0);
         e_full[k]  = (q[k].size() == DEPTH);
         e_af[k]    = (q[k].size() >= AF_LVL);
         e_cnt[k*CNT_W +: CNT_W] = CNT_W'(q[k].size());
      end
      chk("empty", 64'(empty), 64'(e_empty));
      chk("full", 64'(full), 64'(e_full));
      chk("almost_full", 64'(almost_full), 64'(e_af));
      chk("count", 64'(count), 64'(e_cnt));
      chk("polarity", 64'(polarity), 64'(exp_pol));
      chk("ovf_err", 64'(ovf_err), 64'(exp_ovf));
      chk("udf_err", 64'(udf_err), 64'(exp_udf));
      rv = int'(rd_vc);
      if (rv < NUM_VC) begin
         if (q[rv].size() > 0) chk("dout", dout, q[rv][0]);
      end
   endtask

   task automatic step(input bit we, input logic [1:0] wvc, input logic [63:0] d,
                       input bit re, input logic [1:0] rvc);
      wr_en = we; wr_vc = wvc; din = d; rd_en = re; rd_vc = rvc;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      wr_en = 1'b0; wr_vc = '0; din = '0; rd_en = 1'b0; rd_vc = '0;
      @(negedge clk);
      rst = 1'b1;
      model_clear();
      #1;
      check_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      wr_en = 1'b0; wr_vc = '0; din = '0; rd_en = 1'b0; rd_vc = '0;
      model_clear();

      for (int i = 0; i < 8; i++) tbl[i] = '{1, 0, A + 64'(i), 0, 0, i + 1, 0, 0, 0, 1, A};
      tbl[8]  = '{1, 0, A + 64'd8, 1, 0, 8, 0, 0, 0, 1, A + 64'd1};
      tbl[9]  = '{1, 0, A + 64'd9, 0, 0, 8, 0, 1, 0, 1, A + 64'd1};
      tbl[10] = '{1, 1, B0, 1, 0, 7, 1, 1, 0, 1, A + 64'd2};
      tbl[11] = '{0, 0, 0, 0, 1, 7, 1, 1, 0, 1, B0};
      tbl[12] = '{0, 0, 0, 1, 1, 7, 0, 1, 0, 0, 0};
      tbl[13] = '{0, 0, 0, 1, 1, 7, 0, 1, 1, 0, 0};
      for (int i = 0; i < 7; i++)
         tbl[14 + i] = '{0, 0, 0, 1, 0, 6 - i, 0, 1, 1, (i < 6), A + 64'(3 + i)};
      tbl[21] = '{1, 0, C0, 1, 0, 1, 0, 1, 1, 1, C0};

      #1;
      check_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 22; i++) begin
         step(tbl[i].we, tbl[i].wvc, tbl[i].d, tbl[i].re, tbl[i].rvc);
         chk($sformatf("tbl%0d_cnt0", i), 64'(count[0 +: CNT_W]), 64'(tbl[i].c0));
         chk($sformatf("tbl%0d_cnt1", i), 64'(count[CNT_W +: CNT_W]), 64'(tbl[i].c1));
         chk($sformatf("tbl%0d_ovf", i), 64'(ovf_err), 64'(tbl[i].ovf));
         chk($sformatf("tbl%0d_udf", i), 64'(udf_err), 64'(tbl[i].udf));
         if (tbl[i].dchk) chk($sformatf("tbl%0d_dout", i), dout, tbl[i].dexp);
      end
      chk("tbl_empty1", 64'(empty[1]), 64'd1);

      // Streaming through VC0 across pointer wraps.
      do_reset();
      step(1, 0, S, 0, 0);
      for (int i = 1; i < 20; i++) begin
         step(1, 0, S + 64'(i), 1, 0);
         chk("stream_dout", dout, S + 64'(i));
         chk("stream_cnt", 64'(count[0 +: CNT_W]), 64'd1);
      end
      step(0, 0, 0, 1, 0);
      chk("stream_errs", 64'({ovf_err, udf_err}), 64'd0);

      // Out-of-range VC numbers.
      do_reset();
      step(1, 2'd3, 64'h33, 0, 0);
      chk("oor_wr_ovf", 64'(ovf_err), 64'd1);
      step(0, 0, 0, 1, 2'd3);
      chk("oor_rd_udf", 64'(udf_err), 64'd1);

      // Random traffic against the queue model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step(bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              {$urandom, $urandom}, bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end

      // Asynchronous reset between edges with flits queued.
      step(1, 1, 64'h77, 0, 1);
      @(posedge clk);
      model_edge();
      #3;
      rst = 1'b1;
      #1;
      model_clear();
      chk("arst_empty", 64'(empty), 64'b111);
      chk("arst_full", 64'(full), 64'd0);
      chk("arst_af", 64'(almost_full), 64'd0);
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_pol", 64'(polarity), 64'd0);
      chk("arst_errs", 64'({ovf_err, udf_err}), 64'd0);
      @(posedge clk);
      #1;
      chk("arst_hold_pol", 64'(polarity), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      step(1, 2, C0, 0, 2);
      chk("post_rst_cnt2", 64'(count[2*CNT_W +: CNT_W]), 64'd1);
      chk("post_rst_dout", dout, C0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/noc_vc_fifo.md
NOC_VC_FIFO -- requirements
Module: noc_vc_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 64, flit width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, entries per virtual channel (VC); power of two, >= 2.
REQ-003 SHALL have parameter NUM_VC, default 2, number of independent VC queues, >= 1.
REQ-004 SHALL have parameter AF_LVL, default DEPTH-2, occupancy at or above which almost_full asserts.
REQ-005 SHALL derive VC_W = max(1, clog2(NUM_VC)) and CNT_W = clog2(DEPTH)+1.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_vc  input  VC_W  target VC of the write.
REQ-010 din  input  DATA_W  write flit.
REQ-011 rd_en  input  1  read (pop) request.
REQ-012 rd_vc  input  VC_W  source VC of the read and of dout.
REQ-013 dout  output  DATA_W  head flit of VC rd_vc.
REQ-014 empty  output  NUM_VC  per-VC empty flags.
REQ-015 full  output  NUM_VC  per-VC full flags.
REQ-016 almost_full  output  NUM_VC  per-VC occupancy >= AF_LVL.
REQ-017 count  output  NUM_VC*CNT_W  per-VC occupancy; VC k occupies bits [k*CNT_W +: CNT_W].
REQ-018 polarity  output  1  even/odd cycle indicator for the router.
REQ-019 ovf_err  output  1  sticky: write refused.
REQ-020 udf_err  output  1  sticky: read refused.

Function
REQ-021 Each VC SHALL have private storage of DEPTH entries and private write/read pointers of CNT_W bits (extra wrap bit).
REQ-022 empty[k] SHALL equal (wptr==rptr); full[k] SHALL equal (MSBs differ and lower bits equal); both combinational from registered pointers.
REQ-023 count[k] SHALL equal wptr-rptr modulo 2^CNT_W, range 0..DEPTH.
REQ-024 A write SHALL be accepted at a rising edge iff wr_en=1 and (full[wr_vc]=0 or a read of the same VC is accepted that edge); accepted write stores din and increments that VC's wptr.
REQ-025 A read SHALL be accepted iff rd_en=1 and empty[rd_vc]=0; accepted read increments that VC's rptr.
REQ-026 Write to one VC and read from another in the same cycle SHALL both proceed independently.
REQ-027 Simultaneous accepted write and read on same non-empty VC SHALL leave count unchanged; on an empty VC the read SHALL be refused and the write accepted.
REQ-028 dout SHALL be first-word-fall-through: combinational storage[rd_vc][rptr], valid whenever empty[rd_vc]=0; value when empty is don't-care.
REQ-029 Write-to-read latency SHALL be one cycle: flit written at edge N is visible on dout after edge N.
REQ-030 Pointer wrap SHALL be natural CNT_W-bit rollover; no data corruption across wrap.
REQ-031 wr_vc or rd_vc >= NUM_VC SHALL be treated as a refused request of the same kind.
REQ-032 polarity SHALL toggle every clock edge when not in reset.
REQ-033 ovf_err SHALL set on any refused write request; udf_err SHALL set on any refused read request; both clear only on reset.

Reset
REQ-034 rst=1 SHALL immediately clear all pointers, polarity, ovf_err, udf_err, giving empty=all ones, full=0, almost_full=0 (for AF_LVL>0), count=0.
REQ-035 Storage contents SHALL not be reset; reset mid-operation SHALL discard all queued flits.
REQ-036 After rst deasserts, first accepted operations SHALL occur at the next rising edge.

Verification
REQ-037 Reset, then write A0..A7 to VC0, 8 edges -> full[0]=1, count VC0=8, almost_full[0]=1 from count 6, empty[1]=1.
REQ-038 VC0 full, wr_en+rd_en on VC0 same edge with din=A8 -> dout=A1 next, count stays 8, ovf_err=0; then wr_en only -> ovf_err=1, count 8.
REQ-039 Interleave: write B0 to VC1 and pop VC0 same edge -> count VC1=1, VC0 decrements, dout(rd_vc=1)=B0.
REQ-040 rd_en on empty VC1 -> udf_err=1, pointers unchanged; write C0 + read on empty VC0 same edge -> count 1, dout=C0.
REQ-041 Stream 20 flits through VC0 with continuous write/read -> data order preserved across two pointer wraps, no errors.
REQ-042 Assert rst asynchronously between edges with data queued -> outputs reach reset values without a clock edge; polarity=0.
